// File: rtl/multicycle_control_unit_if.sv
// Control-side bundle of the multicycle datapath: instruction fields and ALU
// flags in, mux selects, ALU command and write enables out.
interface multicycle_control_unit_if;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] flags;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_control;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [3:0] state;

  modport slave (
    input  cond, op, funct, rd, flags,
    output pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
           alu_src_b, alu_control, result_src, imm_src, reg_src, state
  );

  modport master (
    output cond, op, funct, rd, flags,
    input  pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
           alu_src_b, alu_control, result_src, imm_src, reg_src, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle ARM-subset datapath, holding the NZCV
// flag register and gating every architectural write on the condition field.
module multicycle_control_unit (
  input  logic                       clk,
  input  logic                       rst,
  multicycle_control_unit_if.slave   ctl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] nzcv_q, nzcv_d;

  logic       cond_ex_s;
  logic [1:0] dp_alu_s;
  logic       no_write_s;
  logic       set_flags_s;
  logic       cv_en_s;
  logic       is_execute_s;

  logic       pc_we_s, ir_we_s, reg_we_s, mem_we_s;
  logic       adr_src_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, alu_control_s, result_src_s;
  logic [1:0] imm_src_s, reg_src_s;

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return cy;
      4'b0011: return !cy;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return cy && !z;
      4'b1001: return !cy || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign cond_ex_s    = cond_check(ctl.cond, nzcv_q);
  assign is_execute_s = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

  // Data-processing command decode; unknown commands run as a silent ADD.
  always_comb begin
    dp_alu_s    = 2'b00;
    no_write_s  = 1'b1;
    set_flags_s = 1'b0;
    cv_en_s     = 1'b0;
    case (ctl.funct[4:1])
      4'b0100: begin dp_alu_s = 2'b00; no_write_s = 1'b0; set_flags_s = ctl.funct[0]; cv_en_s = 1'b1; end
      4'b0010: begin dp_alu_s = 2'b01; no_write_s = 1'b0; set_flags_s = ctl.funct[0]; cv_en_s = 1'b1; end
      4'b0000: begin dp_alu_s = 2'b10; no_write_s = 1'b0; set_flags_s = ctl.funct[0]; end
      4'b1100: begin dp_alu_s = 2'b11; no_write_s = 1'b0; set_flags_s = ctl.funct[0]; end
      4'b1010: begin dp_alu_s = 2'b01; set_flags_s = 1'b1; cv_en_s = 1'b1; end
      default: begin end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Flag register; logical ops leave C and V untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nzcv_q <= 4'b0000;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  // Flag next value, loaded only by a passing flag-setting execute cycle.
  always_comb begin
    nzcv_d = nzcv_q;
    if (is_execute_s && set_flags_s && cond_ex_s) begin
      nzcv_d[3:2] = ctl.flags[3:2];
      if (cv_en_s) begin
        nzcv_d[1:0] = ctl.flags[1:0];
      end else begin
        nzcv_d[1:0] = nzcv_q[1:0];
      end
    end else begin
      nzcv_d = nzcv_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.op)
          2'b00:   state_d = ctl.funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = ctl.funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI: state_d = no_write_s ? S_FETCH : S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode; only write enables and alu_control see the instruction.
  always_comb begin
    pc_we_s       = 1'b0;
    ir_we_s       = 1'b0;
    reg_we_s      = 1'b0;
    mem_we_s      = 1'b0;
    adr_src_s     = 1'b0;
    alu_src_a_s   = 1'b0;
    alu_src_b_s   = 2'b00;
    alu_control_s = 2'b00;
    result_src_s  = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_we_s      = 1'b1;
        pc_we_s      = 1'b1;
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
      end
      S_MEMREAD:  adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = 2'b01;
        if (ctl.rd == 4'd15) begin
          pc_we_s = cond_ex_s;
        end else begin
          reg_we_s = cond_ex_s;
        end
      end
      S_MEMWRITE: begin
        adr_src_s = 1'b1;
        mem_we_s  = cond_ex_s;
      end
      S_EXECUTER: begin
        alu_src_b_s   = 2'b01;
        alu_control_s = dp_alu_s;
      end
      S_EXECUTEI: alu_control_s = dp_alu_s;
      S_ALUWB: begin
        if (ctl.rd == 4'd15) begin
          pc_we_s = cond_ex_s;
        end else begin
          reg_we_s = cond_ex_s;
        end
      end
      S_BRANCH: begin
        result_src_s = 2'b10;
        pc_we_s      = cond_ex_s;
      end
      default: begin end
    endcase
  end

  // Immediate format and register-port steering follow the op field alone.
  always_comb begin
    case (ctl.op)
      2'b01:   imm_src_s = 2'b01;
      2'b10:   imm_src_s = 2'b10;
      default: imm_src_s = 2'b00;
    endcase
    reg_src_s = {(ctl.op == 2'b01) && !ctl.funct[0], ctl.op == 2'b10};
  end

  assign ctl.pc_write    = rst & pc_we_s;
  assign ctl.ir_write    = rst & ir_we_s;
  assign ctl.reg_write   = rst & reg_we_s;
  assign ctl.mem_write   = rst & mem_we_s;
  assign ctl.adr_src     = adr_src_s;
  assign ctl.alu_src_a   = alu_src_a_s;
  assign ctl.alu_src_b   = alu_src_b_s;
  assign ctl.alu_control = alu_control_s;
  assign ctl.result_src  = result_src_s;
  assign ctl.imm_src     = imm_src_s;
  assign ctl.reg_src     = reg_src_s;
  assign ctl.state       = state_q;

endmodule
